// File: rtl/sd_pkg.sv
// Shared types and constants for the sequence-detector serial front end.
package sd_pkg;

  // Serializer control states: IDLE has nothing in flight, SHIFT is emitting a word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default parallel word width.
  localparam int SD_WORD_W = 6;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sd_shift_reg.sv
// WIDTH-bit load/shift register. The output is the bit that will sit at the
// head position after this clock edge, so the parent can register it directly.
module sd_shift_reg #(
  parameter int WIDTH     = sd_pkg::SD_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head_next
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;

  // Load takes priority over shift; shifting moves the next bit into the head slot.
  always_comb begin
    w_data_next = r_data;
    if (i_load) begin
      w_data_next = i_data;
    end else if (i_shift) begin
      if (MSB_FIRST) begin
        w_data_next = {r_data[WIDTH-2:0], 1'b0};
      end else begin
        w_data_next = {1'b0, r_data[WIDTH-1:1]};
      end
    end
  end

  // Register the shift contents; reset clears any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_data_next;
    end
  end

  assign o_head_next = MSB_FIRST ? w_data_next[WIDTH-1] : w_data_next[0];

endmodule

// File: rtl/sd_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one bit per clock out,
// with a single holding register so consecutive words stream without a gap.
module sd_serializer
  import sd_pkg::*;
#(
  parameter int WIDTH     = SD_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             stream_out,
  output logic             stream_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   w_bit_cnt_next;
  logic               r_hold_full;
  logic               w_hold_full_next;
  logic [WIDTH-1:0]   r_hold_data;
  logic [WIDTH-1:0]   w_load_data;
  logic               w_load;
  logic               w_shift;
  logic               w_hold_load;
  logic               w_hold_clear;
  logic               w_handshake;
  logic               w_head_next;
  logic               r_stream_out;
  logic               r_stream_valid;
  logic               r_word_done;
  logic               r_busy;

  // Ready only depends on the holding register, so upstream sees it combinationally.
  assign data_ready  = !r_hold_full;
  assign w_handshake = data_valid && data_ready;

  // Next-state, counter and datapath control. On the last bit a queued word
  // (held or arriving now) reloads the shifter so the stream has no gap.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_load_data    = data_in;
    w_hold_load    = 1'b0;
    w_hold_clear   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_load         = 1'b1;
          w_state_next   = SHIFT;
          w_bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (r_bit_cnt != LAST_CNT) begin
          w_shift        = 1'b1;
          w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          w_hold_load    = w_handshake;
        end else begin
          w_bit_cnt_next = '0;
          if (r_hold_full) begin
            w_load       = 1'b1;
            w_load_data  = r_hold_data;
            w_hold_clear = 1'b1;
          end else if (w_handshake) begin
            w_load = 1'b1;
          end else begin
            w_shift      = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_hold_full_next = (r_hold_full || w_hold_load) && !w_hold_clear;

  sd_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_data      (w_load_data),
    .o_head_next (w_head_next)
  );

  // State, counter and holding register; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_hold_full <= w_hold_full_next;
      if (w_hold_load) begin
        r_hold_data <= data_in;
      end
    end
  end

  // Registered outputs computed from next-state values; the bit is masked when not shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stream_out   <= 1'b0;
      r_stream_valid <= 1'b0;
      r_word_done    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_stream_out   <= (w_state_next == SHIFT) && w_head_next;
      r_stream_valid <= (w_state_next == SHIFT);
      r_word_done    <= (w_state_next == SHIFT) && (w_bit_cnt_next == LAST_CNT);
      r_busy         <= (w_state_next == SHIFT) || w_hold_full_next;
    end
  end

  assign stream_out   = r_stream_out;
  assign stream_valid = r_stream_valid;
  assign word_done    = r_word_done;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sd_serializer.sv
// Randomized self-checking bench: two serializers (MSB-first and LSB-first)
// share inputs and are compared every cycle against a queue-based model.
module tb_sd_serializer;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         ready_m, out_m, valid_m, done_m, busy_m;
  logic         ready_l, out_l, valid_l, done_l, busy_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of bits still to appear, each entry {last_of_word, bit}.
  // The front entry is the bit currently on the stream.
  logic [1:0] q_msb[$];
  logic [1:0] q_lsb[$];
  logic       exp_hs;

  always #5 clk = ~clk;

  sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_m),
    .stream_out   (out_m),
    .stream_valid (valid_m),
    .word_done    (done_m),
    .busy         (busy_m)
  );

  sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_l),
    .stream_out   (out_l),
    .stream_valid (valid_l),
    .word_done    (done_l),
    .busy         (busy_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int         n;
    logic [1:0] hm;
    logic [1:0] hl;
    n  = q_msb.size();
    hm = (n > 0) ? q_msb[0] : 2'b00;
    hl = (n > 0) ? q_lsb[0] : 2'b00;
    check_eq("msb_valid", valid_m, n > 0);
    check_eq("msb_out",   out_m,   hm[0]);
    check_eq("msb_done",  done_m,  hm[1]);
    check_eq("msb_busy",  busy_m,  n > 0);
    check_eq("msb_ready", ready_m, n <= W);
    check_eq("lsb_valid", valid_l, n > 0);
    check_eq("lsb_out",   out_l,   hl[0]);
    check_eq("lsb_done",  done_l,  hl[1]);
    check_eq("lsb_busy",  busy_l,  n > 0);
    check_eq("lsb_ready", ready_l, n <= W);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) q_msb.push_back({i == 0, w[i]});
    for (int i = 0; i < W; i++)      q_lsb.push_back({i == W - 1, w[i]});
  endtask

  // One clock: check outputs, drive inputs, then advance the model at the edge.
  // A word is taken whenever valid is high and at most one word is in flight.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    check_outputs();
    rst        = r;
    data_valid = v;
    data_in    = d;
    exp_hs     = !r && v && (q_msb.size() <= W);
    @(posedge clk);
    if (r) begin
      q_msb.delete();
      q_lsb.delete();
      $display("[TB] t=%0t reset", $time);
    end else begin
      if (q_msb.size() > 0) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
      if (exp_hs) begin
        push_word(d);
        $display("[TB] t=%0t accept word %b", $time, d);
      end
    end
  endtask

  // Hold data_valid with the same word until it is accepted (bounded).
  task automatic send_word(input logic [W-1:0] w);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, w, 1'b0);
      ok = exp_hs;
    end
    check_eq("accept", ok, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    @(posedge clk);
    @(posedge clk);
    step(1'b0, '0, 1'b1);
    idle(2);

    // Single word, then gap back to idle.
    send_word(6'b110101);
    idle(8);

    // Back-to-back words through the holding register, with changing data
    // presented while the block is not ready.
    send_word(6'b110100);
    send_word(6'b101011);
    for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0);
    idle(14);

    // Bypass: second word offered only during the first word's last bit.
    send_word(6'b101101);
    idle(5);
    step(1'b1, 6'b011001, 1'b0);
    idle(8);

    // Reset after three bits, then a fresh word.
    send_word(6'b111000);
    idle(3);
    step(1'b0, '0, 1'b1);
    send_word(6'b000111);
    idle(8);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 99) == 0);
    end
    idle(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
